// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronised line, 3-sample majority vote at mid-bit,
// frames delivered as single bytes on an AXI-Stream master port.
module uart_rx_core #(
    parameter int system_clk = 50000000,
    parameter int band_rate  = 115200,
    parameter int data_bits  = 8,
    parameter int check_mode = 1,
    parameter int stop_mode  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic                 m_axis_tready,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 check_flag,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BAUD_DIV = system_clk / band_rate;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] SMP0     = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP1     = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP2     = CNT_W'(HALF + 1);
    localparam logic [2:0]       LAST_DATA  = 3'(data_bits - 1);
    localparam logic [2:0]       LAST_STOP  = 3'(stop_mode);
    localparam bit               HAS_PARITY = (check_mode != 0);
    localparam bit               ODD_PARITY = (check_mode == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_rxMeta;
    logic                 r_rxSync;
    logic                 r_rxPrev;
    logic [CNT_W-1:0]     r_baudCnt;
    logic                 r_samp0;
    logic                 r_samp1;
    logic [2:0]           r_bitCnt;
    logic [data_bits-1:0] r_shift;
    logic                 r_perr;
    logic                 r_deliver;
    logic [data_bits-1:0] r_tdata;
    logic                 r_tvalid;
    logic                 r_checkFlag;
    logic                 r_frameErr;
    logic                 r_overrun;

    logic                 w_fallEdge;
    logic                 w_tick;
    logic                 w_majority;
    logic                 w_deliver;
    logic                 w_frameErr;

    assign w_fallEdge = r_rxPrev & ~r_rxSync;
    assign w_tick     = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH) && (r_baudCnt == SMP2);
    assign w_majority = (r_samp0 & r_samp1) | (r_samp0 & r_rxSync) | (r_samp1 & r_rxSync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
            r_state  <= S_IDLE;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
            r_state  <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_deliver   = 1'b0;
        w_frameErr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_en && w_fallEdge)
                    w_nextState = S_START;
            end
            S_START: begin
                if (w_tick)
                    w_nextState = w_majority ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bitCnt == LAST_DATA))
                    w_nextState = HAS_PARITY ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_tick)
                    w_nextState = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (!w_majority) begin
                        w_frameErr  = 1'b1;
                        w_nextState = S_WAIT_HIGH;
                    end else if (r_bitCnt == LAST_STOP) begin
                        w_deliver   = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not be re-read as a string of start bits.
                if (r_rxSync)
                    w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // The baud counter sits at zero in IDLE so every frame is timed from its own start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baudCnt <= '0;
            r_samp0   <= 1'b1;
            r_samp1   <= 1'b1;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_deliver <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT_HIGH)
                r_baudCnt <= '0;
            else if (r_baudCnt == CNT_LAST)
                r_baudCnt <= '0;
            else
                r_baudCnt <= r_baudCnt + 1'b1;

            if (r_baudCnt == SMP0)
                r_samp0 <= r_rxSync;
            if (r_baudCnt == SMP1)
                r_samp1 <= r_rxSync;

            if (w_nextState != r_state)
                r_bitCnt <= '0;
            else if (w_tick)
                r_bitCnt <= r_bitCnt + 1'b1;

            if (r_state == S_DATA && w_tick)
                r_shift <= {w_majority, r_shift[data_bits-1:1]};

            if (r_state == S_START)
                r_perr <= 1'b0;
            else if (r_state == S_PARITY && w_tick)
                r_perr <= (^r_shift) ^ w_majority ^ ODD_PARITY;

            r_deliver <= w_deliver;
        end
    end

    // A completed word is dropped (not queued) when the previous one is still stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_checkFlag <= 1'b0;
            r_frameErr  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frameErr <= w_frameErr;
            r_overrun  <= 1'b0;
            if (r_deliver) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata     <= r_shift;
                    r_checkFlag <= r_perr;
                    r_tvalid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign check_flag    = r_checkFlag;
    assign frame_err     = r_frameErr;
    assign overrun       = r_overrun;

endmodule
